// File: rtl/ysyx_23060180_mem_bridge_if.sv
// Core/SRAM/UART bus bundle for ysyx_23060180_mem_bridge.
// "slave" is the bridge's view; "master" is the surrounding core, RAM and UART.
interface ysyx_23060180_mem_bridge_if;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_raddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wbit_en;
    logic [31:0] mem_rdata;

    logic        sram_en;
    logic        sram_we;
    logic [29:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_wmask;
    logic [31:0] sram_rdata;

    logic        uart_valid;
    logic [7:0]  uart_data;
    logic        uart_ready;

    modport slave (
        input  mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en,
        output mem_rdata,
        output sram_en, sram_we, sram_addr, sram_wdata, sram_wmask,
        input  sram_rdata,
        output uart_valid, uart_data,
        input  uart_ready
    );

    modport master (
        output mem_rd, mem_wr, mem_raddr, mem_wdata, mem_wbit_en,
        input  mem_rdata,
        input  sram_en, sram_we, sram_addr, sram_wdata, sram_wmask,
        output sram_rdata,
        input  uart_valid, uart_data,
        output uart_ready
    );
endinterface

// File: rtl/ysyx_23060180_mem_bridge.sv
// Core memory bridge: routes loads/stores to SRAM, a 4-deep serial TX FIFO and an RTC.
// Optional 64-bit RTC counter is built only when YSYX_23060180_RTC_EN is defined.
module ysyx_23060180_mem_bridge (
    input  logic                             clk,
    input  logic                             rstn_in,
    ysyx_23060180_mem_bridge_if.slave        bus,
    output logic                             misalign_err
);
    localparam logic [31:0] SERIAL_DATA = 32'hA000_03F8;
    localparam logic [31:0] SERIAL_STAT = 32'hA000_03FC;
    localparam logic [31:0] RTC_LO      = 32'hA000_0048;
    localparam logic [31:0] RTC_HI      = 32'hA000_004C;

    typedef enum logic [1:0] {RSP_NONE, RSP_RAM, RSP_REG} rsp_e;

    rsp_e        rsp_q, rsp_d;
    logic [1:0]  off_q;
    logic [31:0] rd_data_q, rd_data_d;
    logic        misalign_err_q;

    logic [7:0]  fifo_mem [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;

    logic [31:0] rtc_lo_val;
    logic [31:0] rtc_hi_val;

    // ---------------- request decode ----------------
    logic [1:0] off;
    logic       req_rd, req_wr, ram_hit, size_ok, misaligned;
    logic       ram_rd, ram_wr;
    logic [3:0] base_mask;

    assign off        = bus.mem_raddr[1:0];
    assign req_rd     = rstn_in && bus.mem_rd;
    assign req_wr     = rstn_in && bus.mem_wr;
    assign ram_hit    = (bus.mem_raddr[31:27] == 5'b10000);
    assign size_ok    = (bus.mem_wbit_en == 4'd1) || (bus.mem_wbit_en == 4'd2) ||
                        (bus.mem_wbit_en == 4'd4);
    assign misaligned = ((bus.mem_wbit_en == 4'd2) && off[0]) ||
                        ((bus.mem_wbit_en == 4'd4) && (off != 2'd0));
    // A simultaneous write wins the RAM port; the read half then answers 0.
    assign ram_rd     = req_rd && !bus.mem_wr && ram_hit && !misaligned;
    assign ram_wr     = req_wr && ram_hit && !misaligned && size_ok;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        base_mask = 4'b0000;
        case (bus.mem_wbit_en)
            4'd1:    base_mask = 4'b0001;
            4'd2:    base_mask = 4'b0011;
            4'd4:    base_mask = 4'b1111;
            default: base_mask = 4'b0000;
        endcase
    end

    assign bus.sram_en    = ram_rd || ram_wr;
    assign bus.sram_we    = ram_wr;
    assign bus.sram_addr  = bus.mem_raddr[31:2];
    assign bus.sram_wmask = ram_wr ? (base_mask << off) : 4'b0000;
    assign bus.sram_wdata = bus.mem_wdata << {off, 3'b000};

    // ---------------- serial TX FIFO ----------------
    logic push, pop, full, accept, drop;

    assign full           = (count_q == 3'd4);
    assign bus.uart_valid = rstn_in && (count_q != 3'd0);
    assign bus.uart_data  = fifo_mem[rd_ptr_q];
    assign pop            = bus.uart_valid && bus.uart_ready;
    assign push           = req_wr && (bus.mem_raddr == SERIAL_DATA);
    assign accept         = push && (!full || pop);
    assign drop           = push && full && !pop;

    always_comb begin
        wr_ptr_d   = accept ? wr_ptr_q + 2'd1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
        count_d    = count_q;
        drop_cnt_d = drop_cnt_q;
        if (accept && !pop)      count_d = count_q + 3'd1;
        else if (pop && !accept) count_d = count_q - 3'd1;
        if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
    end

    // NOTE: FIFO storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) fifo_mem[wr_ptr_q] <= bus.mem_wdata[7:0];
    end

    // ---------------- RTC ----------------
`ifdef YSYX_23060180_RTC_EN
    logic [63:0] rtc_q;
    logic [31:0] rtc_hi_q;

    // Reading the low word snapshots the high word so a LO/HI pair is coherent.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            rtc_q    <= '0;
            rtc_hi_q <= '0;
        end else begin
            rtc_q <= rtc_q + 64'd1;
            if (req_rd && !bus.mem_wr && (bus.mem_raddr == RTC_LO)) rtc_hi_q <= rtc_q[63:32];
        end
    end

    assign rtc_lo_val = rtc_q[31:0];
    assign rtc_hi_val = rtc_hi_q;
`else
    assign rtc_lo_val = 32'd0;
    assign rtc_hi_val = 32'd0;
`endif

    // ---------------- read response ----------------
    always_comb begin
        rsp_d     = RSP_NONE;
        rd_data_d = '0;
        if (req_rd) begin
            if (ram_rd) begin
                rsp_d = RSP_RAM;
            end else begin
                rsp_d = RSP_REG;
                if (!bus.mem_wr) begin
                    case (bus.mem_raddr)
                        SERIAL_STAT: rd_data_d = {16'b0, drop_cnt_q, 5'b0, count_q};
                        RTC_LO:      rd_data_d = rtc_lo_val;
                        RTC_HI:      rd_data_d = rtc_hi_val;
                        default:     rd_data_d = '0;
                    endcase
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rstn_in) begin
            rsp_q          <= RSP_NONE;
            off_q          <= 2'd0;
            rd_data_q      <= '0;
            misalign_err_q <= 1'b0;
            wr_ptr_q       <= 2'd0;
            rd_ptr_q       <= 2'd0;
            count_q        <= 3'd0;
            drop_cnt_q     <= 8'd0;
        end else begin
            rsp_q      <= rsp_d;
            off_q      <= off;
            rd_data_q  <= rd_data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            drop_cnt_q <= drop_cnt_d;
            if ((req_rd || req_wr) && ram_hit && misaligned) misalign_err_q <= 1'b1;
        end
    end

    always_comb begin
        bus.mem_rdata = '0;
        if (rstn_in) begin
            case (rsp_q)
                RSP_RAM: bus.mem_rdata = bus.sram_rdata >> {off_q, 3'b000};
                RSP_REG: bus.mem_rdata = rd_data_q;
                default: bus.mem_rdata = '0;
            endcase
        end
    end

    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_ysyx_23060180_mem_bridge.sv
// Directed self-checking bench for ysyx_23060180_mem_bridge with a behavioural SRAM.
module tb_ysyx_23060180_mem_bridge;
    logic clk = 1'b0;
    logic rstn_in;
    logic misalign_err;
    int   cmp_cnt = 0;
    int   err_cnt = 0;

    localparam logic [31:0] SERIAL_DATA = 32'hA000_03F8;
    localparam logic [31:0] SERIAL_STAT = 32'hA000_03FC;
    localparam logic [31:0] RTC_LO      = 32'hA000_0048;
    localparam logic [31:0] RTC_HI      = 32'hA000_004C;

    ysyx_23060180_mem_bridge_if bus ();

    ysyx_23060180_mem_bridge dut (
        .clk          (clk),
        .rstn_in      (rstn_in),
        .bus          (bus),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, one-cycle read latency, byte-masked writes.
    logic [31:0] sram_mem [256];
    always @(posedge clk) begin
        if (bus.sram_en) begin
            if (bus.sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (bus.sram_wmask[b]) sram_mem[bus.sram_addr[7:0]][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            end else begin
                bus.sram_rdata <= sram_mem[bus.sram_addr[7:0]];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] size);
        bus.mem_rd      = rd;
        bus.mem_wr      = wr;
        bus.mem_raddr   = addr;
        bus.mem_wdata   = wdata;
        bus.mem_wbit_en = size;
    endtask

    task automatic idle();
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;
    endtask

    task automatic wr_op(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] size);
        drive(1'b0, 1'b1, addr, wdata, size);
        step();
        idle();
    endtask

    task automatic rd_op(input logic [31:0] addr, input logic [3:0] size, output logic [31:0] data);
        drive(1'b1, 1'b0, addr, 32'd0, size);
        step();
        data = bus.mem_rdata;
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rstn_in = 1'b0;
        bus.uart_ready = 1'b0;
        idle();
        step();
        drive(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd4);
        #1;
        cmp_cnt++; if (bus.sram_en !== 1'b0) begin err_cnt++; $display("FAIL rst_sram_en got %b exp 0", bus.sram_en); end
        step();
        idle();
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL rst_rdata got %h exp 0", bus.mem_rdata); end
        cmp_cnt++; if ({bus.sram_we, bus.sram_wmask, bus.uart_valid, misalign_err} !== 7'd0) begin
            err_cnt++; $display("FAIL rst_outs got we=%b mask=%h uv=%b err=%b exp all 0",
                                bus.sram_we, bus.sram_wmask, bus.uart_valid, misalign_err); end
        rstn_in = 1'b1;
        step();
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL rst_release_rdata got %h exp 0", bus.mem_rdata); end
        rd_op(SERIAL_STAT, 4'd4, d);
        cmp_cnt++; if (d !== 32'd0) begin err_cnt++; $display("FAIL rst_stat got %h exp 0", d); end
    endtask

    task automatic test_ram();
        logic [31:0] d;
        drive(1'b0, 1'b1, 32'h8000_0003, 32'h0000_00A5, 4'd1);
        #1;
        cmp_cnt++; if ({bus.sram_en, bus.sram_we, bus.sram_wmask} !== 6'b11_1000) begin
            err_cnt++; $display("FAIL sb_ctrl got en=%b we=%b mask=%b exp 1 1 1000", bus.sram_en, bus.sram_we, bus.sram_wmask); end
        cmp_cnt++; if (bus.sram_addr !== 30'h2000_0000) begin err_cnt++; $display("FAIL sb_addr got %h exp 20000000", bus.sram_addr); end
        cmp_cnt++; if (bus.sram_wdata !== 32'hA500_0000) begin err_cnt++; $display("FAIL sb_wdata got %h exp a5000000", bus.sram_wdata); end
        step();
        drive(1'b1, 1'b0, 32'h8000_0003, 32'd0, 4'd1);
        #1;
        cmp_cnt++; if ({bus.sram_en, bus.sram_we} !== 2'b10) begin err_cnt++; $display("FAIL lb_ctrl got en=%b we=%b exp 1 0", bus.sram_en, bus.sram_we); end
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL lb_req_cycle_rdata got %h exp 0", bus.mem_rdata); end
        step();
        idle();
        cmp_cnt++; if (bus.mem_rdata !== 32'h0000_00A5) begin err_cnt++; $display("FAIL lb_rdata got %h exp 000000a5", bus.mem_rdata); end
        step();
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL idle_rdata got %h exp 0", bus.mem_rdata); end

        drive(1'b0, 1'b1, 32'h8000_0012, 32'h0000_BEEF, 4'd2);
        #1;
        cmp_cnt++; if ({bus.sram_wmask, bus.sram_wdata} !== {4'b1100, 32'hBEEF_0000}) begin
            err_cnt++; $display("FAIL sh_mask_data got %b %h exp 1100 beef0000", bus.sram_wmask, bus.sram_wdata); end
        step();
        idle();
        rd_op(32'h8000_0012, 4'd2, d);
        cmp_cnt++; if (d !== 32'h0000_BEEF) begin err_cnt++; $display("FAIL lh_rdata got %h exp 0000beef", d); end

        wr_op(32'h8000_0020, 32'h1234_5678, 4'd4);
        rd_op(32'h8000_0020, 4'd4, d);
        cmp_cnt++; if (d !== 32'h1234_5678) begin err_cnt++; $display("FAIL lw_rdata got %h exp 12345678", d); end
        rd_op(32'h8000_0021, 4'd1, d);
        cmp_cnt++; if (d !== 32'h0012_3456) begin err_cnt++; $display("FAIL lb_off1_rdata got %h exp 00123456", d); end
    endtask

    task automatic test_misalign();
        logic [31:0] d;
        cmp_cnt++; if (misalign_err !== 1'b0) begin err_cnt++; $display("FAIL mis_pre got %b exp 0", misalign_err); end
        drive(1'b1, 1'b0, 32'h8000_0002, 32'd0, 4'd4);
        #1;
        cmp_cnt++; if (bus.sram_en !== 1'b0) begin err_cnt++; $display("FAIL mis_sram_en got %b exp 0", bus.sram_en); end
        step();
        idle();
        cmp_cnt++; if ({bus.mem_rdata, misalign_err} !== {32'd0, 1'b1}) begin
            err_cnt++; $display("FAIL mis_rsp got rdata=%h err=%b exp 0 1", bus.mem_rdata, misalign_err); end
        drive(1'b0, 1'b1, 32'h8000_0021, 32'h0000_FFFF, 4'd2);
        #1;
        cmp_cnt++; if (bus.sram_en !== 1'b0) begin err_cnt++; $display("FAIL mis_sh_en got %b exp 0", bus.sram_en); end
        step();
        idle();
        rd_op(32'h8000_0020, 4'd4, d);
        cmp_cnt++; if ({d, misalign_err} !== {32'h1234_5678, 1'b1}) begin
            err_cnt++; $display("FAIL mis_sticky got rdata=%h err=%b exp 12345678 1", d, misalign_err); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        drive(1'b1, 1'b0, 32'h9000_0000, 32'd0, 4'd4);
        #1;
        cmp_cnt++; if (bus.sram_en !== 1'b0) begin err_cnt++; $display("FAIL unm_rd_en got %b exp 0", bus.sram_en); end
        step();
        idle();
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL unm_rd got %h exp 0", bus.mem_rdata); end
        wr_op(32'h9000_0000, 32'h0000_0077, 4'd1);
        wr_op(SERIAL_STAT, 32'hFFFF_FFFF, 4'd4);
        rd_op(SERIAL_STAT, 4'd4, d);
        cmp_cnt++; if ({d, bus.uart_valid} !== {32'd0, 1'b0}) begin
            err_cnt++; $display("FAIL unm_wr_effect got stat=%h uv=%b exp 0 0", d, bus.uart_valid); end
        // Read and write together: write lands, read answers 0 despite stale sram_rdata.
        drive(1'b1, 1'b1, 32'h8000_0030, 32'hCAFE_F00D, 4'd4);
        #1;
        cmp_cnt++; if ({bus.sram_en, bus.sram_we} !== 2'b11) begin err_cnt++; $display("FAIL rdwr_ctrl got en=%b we=%b exp 1 1", bus.sram_en, bus.sram_we); end
        step();
        idle();
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL rdwr_rsp got %h exp 0", bus.mem_rdata); end
        rd_op(32'h8000_0030, 4'd4, d);
        cmp_cnt++; if (d !== 32'hCAFE_F00D) begin err_cnt++; $display("FAIL rdwr_stored got %h exp cafef00d", d); end
    endtask

    task automatic test_serial_fifo();
        logic [31:0] d;
        bus.uart_ready = 1'b0;
        for (int i = 1; i <= 6; i++) wr_op(SERIAL_DATA, 32'hABCD_EF00 | i, 4'd1);
        rd_op(SERIAL_STAT, 4'd4, d);
        cmp_cnt++; if (d !== 32'h0000_0204) begin err_cnt++; $display("FAIL fifo_stat_full got %h exp 00000204", d); end
        cmp_cnt++; if ({bus.uart_valid, bus.uart_data} !== {1'b1, 8'h01}) begin
            err_cnt++; $display("FAIL fifo_head got uv=%b data=%h exp 1 01", bus.uart_valid, bus.uart_data); end
        step();
        cmp_cnt++; if (bus.uart_data !== 8'h01) begin err_cnt++; $display("FAIL fifo_hold got %h exp 01", bus.uart_data); end
        bus.uart_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            #1;
            cmp_cnt++; if ({bus.uart_valid, bus.uart_data} !== {1'b1, 8'(i)}) begin
                err_cnt++; $display("FAIL fifo_drain%0d got uv=%b data=%h exp 1 %h", i, bus.uart_valid, bus.uart_data, 8'(i)); end
            step();
        end
        bus.uart_ready = 1'b0;
        rd_op(SERIAL_STAT, 4'd4, d);
        cmp_cnt++; if ({d, bus.uart_valid} !== {32'h0000_0200, 1'b0}) begin
            err_cnt++; $display("FAIL fifo_empty got stat=%h uv=%b exp 00000200 0", d, bus.uart_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] d;
        logic [7:0]  exp_q [4];
        exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
        wr_op(SERIAL_DATA, 32'h11, 4'd1);
        wr_op(SERIAL_DATA, 32'h22, 4'd1);
        wr_op(SERIAL_DATA, 32'h33, 4'd1);
        wr_op(SERIAL_DATA, 32'h44, 4'd1);
        drive(1'b0, 1'b1, SERIAL_DATA, 32'h55, 4'd1);
        bus.uart_ready = 1'b1;
        #1;
        cmp_cnt++; if (bus.uart_data !== 8'h11) begin err_cnt++; $display("FAIL pp_head got %h exp 11", bus.uart_data); end
        step();
        idle();
        bus.uart_ready = 1'b0;
        rd_op(SERIAL_STAT, 4'd4, d);
        cmp_cnt++; if (d !== 32'h0000_0204) begin err_cnt++; $display("FAIL pp_stat got %h exp 00000204", d); end
        bus.uart_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            cmp_cnt++; if ({bus.uart_valid, bus.uart_data} !== {1'b1, exp_q[i]}) begin
                err_cnt++; $display("FAIL pp_drain%0d got uv=%b data=%h exp 1 %h", i, bus.uart_valid, bus.uart_data, exp_q[i]); end
            step();
        end
        bus.uart_ready = 1'b0;
        cmp_cnt++; if (bus.uart_valid !== 1'b0) begin err_cnt++; $display("FAIL pp_empty got %b exp 0", bus.uart_valid); end
    endtask

    task automatic test_rtc();
        logic [31:0] d;
        logic [31:0] exp_lo;
`ifdef YSYX_23060180_RTC_EN
        exp_lo = 32'd100;
`else
        exp_lo = 32'd0;
`endif
        rstn_in = 1'b0;
        step();
        step();
        cmp_cnt++; if ({misalign_err, bus.uart_valid} !== 2'b00) begin
            err_cnt++; $display("FAIL rtc_rst_clear got err=%b uv=%b exp 0 0", misalign_err, bus.uart_valid); end
        rstn_in = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        rd_op(RTC_LO, 4'd4, d);
        cmp_cnt++; if (d !== exp_lo) begin err_cnt++; $display("FAIL rtc_lo got %0d exp %0d", d, exp_lo); end
        rd_op(RTC_HI, 4'd4, d);
        cmp_cnt++; if (d !== 32'd0) begin err_cnt++; $display("FAIL rtc_hi got %h exp 0", d); end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd4);
        step();
        idle();
        rstn_in = 1'b0;
        #1;
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL rmid_rsp got %h exp 0", bus.mem_rdata); end
        drive(1'b1, 1'b0, 32'h8000_0020, 32'd0, 4'd4);
        step();
        cmp_cnt++; if ({bus.mem_rdata, bus.sram_en, bus.sram_we, bus.sram_wmask, bus.uart_valid, misalign_err} !== 40'd0) begin
            err_cnt++; $display("FAIL rmid_outs got rdata=%h en=%b we=%b mask=%h uv=%b err=%b exp all 0",
                                bus.mem_rdata, bus.sram_en, bus.sram_we, bus.sram_wmask, bus.uart_valid, misalign_err); end
        idle();
        rstn_in = 1'b1;
        step();
        cmp_cnt++; if (bus.mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL rmid_release got %h exp 0", bus.mem_rdata); end
    endtask

    initial begin
        bus.sram_rdata  = 32'd0;
        bus.mem_raddr   = 32'd0;
        bus.mem_wdata   = 32'd0;
        bus.mem_wbit_en = 4'd0;
        test_reset();
        test_ram();
        test_misalign();
        test_unmapped();
        test_serial_fifo();
        test_full_push_pop();
        test_rtc();
        test_reset_mid_read();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule

// File: doc/ysyx_23060180_mem_bridge.md
YSYX_23060180_MEM_BRIDGE -- requirements
Module: ysyx_23060180_mem_bridge

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on posedge.
REQ-002 SHALL have ports: rstn_in  in  1  reset, synchronous, active-low.
REQ-003 SHALL have ports: mem_rd  in  1  core read request (one-cycle pulse per access).
REQ-004 SHALL have ports: mem_wr  in  1  core write request.
REQ-005 SHALL have ports: mem_raddr  in  32  byte address for reads and writes.
REQ-006 SHALL have ports: mem_wdata  in  32  store data, LSB-aligned.
REQ-007 SHALL have ports: mem_wbit_en  in  4  store size code: 1=byte, 2=half, 4=word, else none.
REQ-008 SHALL have ports: mem_rdata  out  32  read data, LSB-aligned, valid one cycle after mem_rd.
REQ-009 SHALL have ports: sram_en  out  1, sram_we  out  1, sram_addr  out  30 (word index), sram_wdata  out  32, sram_wmask  out  4  (RAM access); sram_rdata  in  32  valid one cycle after sram_en&&!sram_we.
REQ-010 SHALL have ports: uart_valid  out  1, uart_data  out  8, uart_ready  in  1  (serial TX handshake).
REQ-011 SHALL have ports: misalign_err  out  1  sticky misaligned-access flag.

Function
REQ-012 Address map SHALL be: RAM 0x8000_0000-0x87FF_FFFF; SERIAL_DATA 0xA000_03F8; SERIAL_STAT 0xA000_03FC; RTC_LO 0xA000_0048; RTC_HI 0xA000_004C; all else unmapped.
REQ-013 RAM access SHALL drive sram_en=1 and sram_addr=addr[31:2] in the request cycle; off=addr[1:0].
REQ-014 Store SHALL drive sram_we=1, sram_wmask = {1,3,F}[size] << off, sram_wdata = mem_wdata << 8*off.
REQ-015 Load response SHALL appear in the cycle after mem_rd: mem_rdata = sram_rdata >> 8*off_q (off_q registered), upper bits zero; core performs sign extension.
REQ-016 Misaligned (half with off[0]=1, word with off!=0) SHALL suppress sram_en, return 0 on read, and set misalign_err=1 until reset.
REQ-017 Unmapped read SHALL return 0 in the response cycle; unmapped write SHALL be dropped with no side effect.
REQ-018 mem_rdata SHALL be 0 in every cycle that is not a read-response cycle.
REQ-019 mem_rd and mem_wr together: write SHALL be performed, read treated as unmapped (response 0).
REQ-020 SERIAL TX FIFO: 4 entries, 3-bit count; write to SERIAL_DATA pushes mem_wdata[7:0]; uart_valid = count!=0; uart_data = head entry, stable while uart_valid&&!uart_ready; pop on uart_valid&&uart_ready.
REQ-021 Push when full SHALL be dropped and drop_cnt (8-bit, saturates at 0xFF) SHALL increment; push and pop in the same cycle when full SHALL both succeed, count unchanged.
REQ-022 SERIAL_STAT read SHALL return {16'b0, drop_cnt, 5'b0, count}.
REQ-023 Read pointer and write pointer SHALL wrap modulo 4.

Reset
REQ-024 While rstn_in=0 at posedge: mem_rdata=0, sram_en=0, sram_we=0, sram_wmask=0, uart_valid=0, FIFO empty, pointers 0, drop_cnt=0, misalign_err=0, RTC=0, off_q=0.
REQ-025 A read issued in the cycle before reset asserts SHALL produce no response; first cycle after release mem_rdata=0.
REQ-026 Requests sampled while rstn_in=0 SHALL be ignored.

Configuration
REQ-027 Macro YSYX_23060180_RTC_EN: when defined, a 64-bit counter increments every cycle from 0 after reset; RTC_LO read returns low word and latches the high word into a shadow register; RTC_HI read returns the shadow.
REQ-028 Without YSYX_23060180_RTC_EN, RTC addresses SHALL behave as unmapped (read 0), and no counter logic SHALL exist.

Verification
REQ-029 Store byte 0xA5 to 0x8000_0003 -> sram_wmask=4'b1000, sram_wdata[31:24]=0xA5; later lb at same address -> mem_rdata=0x0000_00A5 one cycle after mem_rd.
REQ-030 Word load from 0x8000_0002 -> sram_en=0, mem_rdata=0, misalign_err=1 and remains 1 over later valid accesses.
REQ-031 Six writes to SERIAL_DATA with uart_ready=0 -> count=4, drop_cnt=2, SERIAL_STAT reads 0x0000_0204; raise uart_ready -> bytes 1-4 emitted in order, count 0.
REQ-032 With FIFO full, push plus uart_ready=1 same cycle -> count stays 4, no drop, new byte emitted last.
REQ-033 RTC_EN defined: read RTC_LO at cycle 100 after reset release -> low word equals elapsed cycles; RTC_HI read after it -> 0; undefined -> both read 0.
REQ-034 Assert rstn_in the cycle after a RAM mem_rd -> mem_rdata=0, no response, all outputs at reset values next cycle.
